// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests with occupancy, full and empty flags.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  wb_req_t       din,
  input  logic          pop,
  output wb_req_t       dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wb_req_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity, so
  // clearing the array would add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the register-file port, late results queue
// in a FIFO, and a scoreboard tracks destinations still awaiting a late result.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [REG_AW-1:0] ll_rd,
  input  logic [XLEN-1:0]   ll_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wd,
  output logic [31:0]       pend,
  output logic [CW-1:0]     ll_count,
  output logic [CNT_W-1:0]  blk_cnt
);

  wb_req_t     head;
  wb_req_t     ll_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic        alu_win;
  logic        pop;
  logic        push;
  logic [31:0] pend_nxt;

  // Writes to x0 are architecturally void, so they neither win nor block.
  assign alu_win  = alu_valid && (alu_rd != '0);
  assign pop      = !alu_win && !fifo_empty;
  assign ll_ready = !fifo_full;
  assign push     = ll_valid && ll_ready && (ll_rd != '0);
  assign ll_req   = '{rd: ll_rd, data: ll_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (ll_req),
    .pop   (pop),
    .dout  (head),
    .count (ll_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else if (alu_win) begin
      rf_we <= 1'b1;
      rf_rd <= alu_rd;
      rf_wd <= alu_data;
    end else if (pop) begin
      rf_we <= 1'b1;
      rf_rd <= head.rd;
      rf_wd <= head.data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    pend_nxt = pend;
    if (pop) pend_nxt[head.rd] = 1'b0;
    if (iss_valid && (iss_rd != '0)) pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Clearing on the pop edge makes the bit drop exactly when rf_we rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     blk_cnt <= '0;
    else if (!fifo_empty && alu_win && blk_cnt != '1) blk_cnt <= blk_cnt + 1'b1;
  end

  a_iss_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (iss_valid && iss_rd != '0) |-> !pend[iss_rd]);
  a_alu_waw: assert property (@(posedge clk) disable iff (!rst_n)
    (alu_valid && alu_rd != '0) |-> !pend[alu_rd]);
  a_ll_orphan: assert property (@(posedge clk) disable iff (!rst_n)
    (ll_valid && ll_rd != '0) |-> pend[ll_rd]);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue model.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alu_valid, ll_valid, iss_valid;
  logic [4:0]        alu_rd, ll_rd, iss_rd;
  logic [XLEN-1:0]   alu_data, ll_data;
  logic              ll_ready, rf_we;
  logic [4:0]        rf_rd;
  logic [XLEN-1:0]   rf_wd;
  logic [31:0]       pend;
  logic [CW-1:0]     ll_count;
  logic [CNT_W-1:0]  blk_cnt;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .pend(pend), .ll_count(ll_count), .blk_cnt(blk_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of late results, pending and outstanding masks.
  wb_req_t         mq[$];
  logic [31:0]     m_pend, m_out;
  logic            m_we;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_wd;
  int unsigned     m_blk;

  task automatic m_reset();
    mq.delete();
    m_pend = '0; m_out = '0;
    m_we = 1'b0; m_rd = '0; m_wd = '0; m_blk = 0;
  endtask

  task automatic model_step();
    bit          acc;
    bit          aw;
    logic [31:0] clr;
    wb_req_t     h;
    acc = ll_valid && (mq.size() < DEPTH);
    aw  = alu_valid && (alu_rd != 0);
    clr = '0;
    if (aw) begin
      m_we = 1'b1; m_rd = alu_rd; m_wd = alu_data;
      if (mq.size() > 0 && m_blk < (2**CNT_W - 1)) m_blk++;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_we = 1'b1; m_rd = h.rd; m_wd = h.data;
      clr[h.rd] = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (acc && ll_rd != 0) begin
      h.rd = ll_rd; h.data = ll_data;
      mq.push_back(h);
      m_out[ll_rd] = 1'b0;
    end
    m_pend = m_pend & ~clr;
    if (iss_valid && iss_rd != 0) begin
      m_pend[iss_rd] = 1'b1;
      m_out[iss_rd]  = 1'b1;
    end
    m_pend[0] = 1'b0;
  endtask

  task automatic compare_all();
    check("rf_we", rf_we, m_we);
    check("rf_rd", rf_rd, m_rd);
    check("rf_wd", rf_wd, m_wd);
    check("pend", pend, m_pend);
    check("ll_count", ll_count, mq.size());
    check("blk_cnt", blk_cnt, m_blk);
  endtask

  task automatic set_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    #1;
    check("ll_ready", ll_ready, mq.size() < DEPTH);
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = {$urandom, $urandom};
      ll_valid = 1'($urandom); ll_rd = 5'($urandom); ll_data = {$urandom, $urandom};
      iss_valid = 1'($urandom); iss_rd = 5'($urandom);
      @(negedge clk);
    end
    m_reset();
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_pend", pend, 32'h0);
    check("rst_ll_count", ll_count, 0);
    check("rst_ll_ready", ll_ready, 1'b1);
    check("rst_blk_cnt", blk_cnt, 0);
    set_idle();
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    int          r;
    int          start;
    set_idle();
    r = $urandom_range(31, 0);
    if ($urandom_range(99, 0) < 60 && !m_pend[r]) begin
      alu_valid = 1'b1; alu_rd = 5'(r); alu_data = {$urandom, $urandom};
    end
    r = $urandom_range(31, 1);
    if ($urandom_range(99, 0) < 30 && !m_pend[r]) begin
      iss_valid = 1'b1; iss_rd = 5'(r);
    end
    if (m_out != 0 && $urandom_range(99, 0) < 50) begin
      start = $urandom_range(31, 0);
      for (int k = 0; k < 32; k++) begin
        if (!ll_valid && m_out[(start + k) % 32]) begin
          ll_valid = 1'b1; ll_rd = 5'((start + k) % 32); ll_data = {$urandom, $urandom};
        end
      end
    end else if ($urandom_range(99, 0) < 5) begin
      ll_valid = 1'b1; ll_rd = 5'd0; ll_data = {$urandom, $urandom};
    end
  endtask

  logic [4:0] exp_ord [4];

  initial begin
    set_idle();
    m_reset();
    @(negedge clk);

    // Reset with random inputs
    do_reset();

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 64'hDEAD;
    step();
    check("alu_we", rf_we, 1'b1);
    check("alu_rd", rf_rd, 5);
    check("alu_wd", rf_wd, 64'hDEAD);
    alu_rd = 0; alu_data = 64'h5555;
    step();
    check("alu_x0_we", rf_we, 1'b0);
    check("alu_x0_hold", rf_wd, 64'hDEAD);

    // Scoreboard set and clear
    set_idle(); iss_valid = 1; iss_rd = 7;
    step();
    check("sb_set", pend[7], 1'b1);
    set_idle(); ll_valid = 1; ll_rd = 7; ll_data = 64'h1234;
    step();
    check("sb_hold", pend[7], 1'b1);
    check("sb_nobypass", rf_we, 1'b0);
    set_idle();
    step();
    check("sb_we", rf_we, 1'b1);
    check("sb_rd", rf_rd, 7);
    check("sb_wd", rf_wd, 64'h1234);
    check("sb_clr", pend[7], 1'b0);

    // Contention, then full boundary
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      set_idle(); iss_valid = 1; iss_rd = 5'(i);
      step();
    end
    for (int i = 0; i < 7; i++) begin
      set_idle();
      alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 64'(i);
      if (i < 4) begin
        ll_valid = 1; ll_rd = 5'(1 + i); ll_data = 64'(32'h100 + i);
      end
      step();
    end
    check("ct_count", ll_count, 4);
    check("ct_ready", ll_ready, 1'b0);
    check("ct_blk", blk_cnt, 6);
    set_idle(); ll_valid = 1; ll_rd = 5; ll_data = 64'h105;
    step();
    check("full_pop_count", ll_count, 3);
    check("full_pop_rd", rf_rd, 1);
    check("full_ready", ll_ready, 1'b1);
    alu_valid = 1; alu_rd = 11; alu_data = 64'hAB;
    step();
    check("full_refill", ll_count, 4);
    exp_ord = '{5'd2, 5'd3, 5'd4, 5'd5};
    set_idle();
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_order", rf_rd, exp_ord[i]);
    end
    check("drain_empty", ll_count, 0);

    // Reset mid-drain
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_idle(); iss_valid = 1; iss_rd = 5'(i);
      step();
    end
    for (int i = 1; i <= 3; i++) begin
      set_idle(); alu_valid = 1; alu_rd = 10; alu_data = 64'(i);
      ll_valid = 1; ll_rd = 5'(i); ll_data = 64'(i);
      step();
    end
    check("md_count", ll_count, 3);
    check("md_pend", pend, 32'h0E);
    set_idle();
    #2 rst_n = 1'b0;
    #1;
    check("md_rst_we", rf_we, 1'b0);
    check("md_rst_pend", pend, 32'h0);
    check("md_rst_count", ll_count, 0);
    check("md_rst_blk", blk_cnt, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("md_no_stale", rf_we, 1'b0);
    end

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
